// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared data-memory width codes, store FSM states and byte-lane merge
package mem_pkg;

  localparam logic [2:0] W_WORD = 3'b001;
  localparam logic [2:0] W_HALF = 3'b010;
  localparam logic [2:0] W_BYTE = 3'b100;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} store_state_t;

  // Word replaces everything; sub-word lanes overwrite rd_q; unknown widths leave rd_q intact.
  function automatic logic [31:0] merge_lanes(
    input logic [2:0]  width,
    input logic [1:0]  pos,
    input logic [31:0] data,
    input logic [31:0] rd_q
  );
    logic [31:0] w_word;
    w_word = rd_q;
    case (width)
      W_WORD: w_word = data;
      W_HALF: begin
        if (pos[1]) w_word[31:16] = data[15:0];
        else        w_word[15:0]  = data[15:0];
      end
      W_BYTE:  w_word[{pos, 3'b000} +: 8] = data[7:0];
      default: w_word = rd_q;
    endcase
    return w_word;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - combinational merge of store data into the read-back word
module store_lane_merge
  import mem_pkg::*;
(
  input  logic [2:0]  i_width,
  input  logic [1:0]  i_pos,
  input  logic [31:0] i_data,
  input  logic [31:0] i_rd_q,
  output logic [31:0] o_merged
);

  assign o_merged = merge_lanes(i_width, i_pos, i_data, i_rd_q);

endmodule

// File: rtl/store_rmw_ctrl.sv
// rtl/store_rmw_ctrl.sv - MEM-stage store sequencer with read-modify-write for sub-word stores
// Optional STORE_MISALIGN_TRAP_EN: trap misaligned stores instead of forcing alignment.
module store_rmw_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_req,
  input  logic [2:0]        st_width,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [31:0]       dmem_rdata,
  output logic              dmem_en,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic              st_ack,
  output logic              stall
`ifdef STORE_MISALIGN_TRAP_EN
  ,
  output logic              st_misalign,
  output logic [ADDR_W-1:0] st_badaddr
`endif
);

  localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

  store_state_t      r_state, w_state_nxt;
  logic [2:0]        r_width;
  logic [1:0]        r_pos;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [31:0]       r_rd_q;
  logic [1:0]        r_cnt;
  logic [1:0]        w_pos;
  logic              w_misalign;
  logic              w_trap;
  logic [31:0]       w_merged;

  assign w_misalign = ((st_width == W_HALF) && st_addr[0]) ||
                      ((st_width == W_WORD) && (st_addr[1:0] != 2'b00));

`ifdef STORE_MISALIGN_TRAP_EN
  logic              r_misalign;
  logic [ADDR_W-1:0] r_badaddr;
  assign w_trap      = w_misalign;
  assign w_pos       = st_addr[1:0];
  assign st_misalign = (r_state == DONE) && r_misalign;
  assign st_badaddr  = r_badaddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
      r_badaddr  <= '0;
    end else if (r_state == IDLE && st_req) begin
      r_misalign <= w_misalign;
      r_badaddr  <= w_misalign ? st_addr : '0;
    end
  end
`else
  // Without the trap, misaligned stores silently snap to their natural alignment.
  assign w_trap = 1'b0;
  always_comb begin
    w_pos = st_addr[1:0];
    if (st_width == W_HALF) w_pos = {st_addr[1], 1'b0};
    else if (st_width == W_WORD) w_pos = 2'b00;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    dmem_en     = 1'b0;
    dmem_we     = 1'b0;
    st_ack      = 1'b0;
    case (r_state)
      IDLE: begin
        if (st_req) begin
          if (w_trap)                                        w_state_nxt = DONE;
          else if (st_width == W_WORD)                       w_state_nxt = WRITE;
          else if (st_width == W_HALF || st_width == W_BYTE) w_state_nxt = READ;
          else                                               w_state_nxt = DONE;
        end
      end
      READ: begin
        dmem_en     = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: if (r_cnt == 2'd0) w_state_nxt = WRITE;
      WRITE: begin
        dmem_en     = 1'b1;
        dmem_we     = 1'b1;
        st_ack      = 1'b1;
        w_state_nxt = IDLE;
      end
      DONE: begin
        st_ack      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_width <= '0;
      r_pos   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rd_q  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && st_req) begin
        r_width <= st_width;
        r_pos   <= w_pos;
        r_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
        r_data  <= st_data;
      end
      if (r_state == READ) r_cnt <= CNT_LOAD;
      if (r_state == WAIT) begin
        if (r_cnt == 2'd0) r_rd_q <= dmem_rdata;
        else               r_cnt  <= r_cnt - 2'd1;
      end
    end
  end

  store_lane_merge u_merge (
    .i_width  (r_width),
    .i_pos    (r_pos),
    .i_data   (r_data),
    .i_rd_q   (r_rd_q),
    .o_merged (w_merged)
  );

  assign dmem_addr  = r_addr;
  assign dmem_wdata = (r_state == WRITE) ? w_merged : 32'h0;
  assign stall      = (st_req | (r_state != IDLE)) & ~st_ack;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// tb/tb_store_rmw_ctrl.sv - bench for store_rmw_ctrl with RD_LAT=1 and RD_LAT=3 instances
module tb_store_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_clr;
  logic [1:0]  st_req;
  logic [2:0]  st_width [2];
  logic [31:0] st_addr [2];
  logic [31:0] st_data [2];
  logic [31:0] dmem_rdata [2];
  logic [1:0]  dmem_en, dmem_we, st_ack, stall;
  logic [31:0] dmem_addr [2];
  logic [31:0] dmem_wdata [2];
`ifdef STORE_MISALIGN_TRAP_EN
  logic [1:0]  st_misalign;
  logic [31:0] st_badaddr [2];
`endif

  logic [31:0] mem [2][1024];
  logic [31:0] pipe [2][4];
  logic [31:0] exp_mem [2][1024];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  store_rmw_ctrl #(.ADDR_W(32), .RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .st_req(st_req[0]), .st_width(st_width[0]), .st_addr(st_addr[0]),
    .st_data(st_data[0]), .dmem_rdata(dmem_rdata[0]), .dmem_en(dmem_en[0]), .dmem_we(dmem_we[0]),
    .dmem_addr(dmem_addr[0]), .dmem_wdata(dmem_wdata[0]), .st_ack(st_ack[0]), .stall(stall[0])
`ifdef STORE_MISALIGN_TRAP_EN
    , .st_misalign(st_misalign[0]), .st_badaddr(st_badaddr[0])
`endif
  );

  store_rmw_ctrl #(.ADDR_W(32), .RD_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .st_req(st_req[1]), .st_width(st_width[1]), .st_addr(st_addr[1]),
    .st_data(st_data[1]), .dmem_rdata(dmem_rdata[1]), .dmem_en(dmem_en[1]), .dmem_we(dmem_we[1]),
    .dmem_addr(dmem_addr[1]), .dmem_wdata(dmem_wdata[1]), .st_ack(st_ack[1]), .stall(stall[1])
`ifdef STORE_MISALIGN_TRAP_EN
    , .st_misalign(st_misalign[1]), .st_badaddr(st_badaddr[1])
`endif
  );

  // Single-port memories; data outside a read's valid slot is poisoned.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_clr) begin
        for (int i = 0; i < 1024; i++) mem[d][i] <= 32'h0;
      end else if (dmem_en[d] && dmem_we[d]) begin
        mem[d][dmem_addr[d][11:2]] <= dmem_wdata[d];
      end
      pipe[d][0] <= (dmem_en[d] && !dmem_we[d]) ? mem[d][dmem_addr[d][11:2]] : 32'hBADBAD00;
      for (int i = 1; i < 4; i++) pipe[d][i] <= pipe[d][i-1];
    end
  end
  assign dmem_rdata[0] = pipe[0][0];
  assign dmem_rdata[1] = pipe[1][2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] old, input logic [2:0] w,
                                             input logic [1:0] pos, input logic [31:0] dat);
    int sh;
    case (w)
      3'b001: return dat;
      3'b010: begin
        sh = pos[1] ? 16 : 0;
        return (old & ~(32'hFFFF << sh)) | ((dat & 32'hFFFF) << sh);
      end
      3'b100: begin
        sh = 8 * int'(pos);
        return (old & ~(32'hFF << sh)) | ((dat & 32'hFF) << sh);
      end
      default: return old;
    endcase
  endfunction

  task automatic do_store(input int d, input logic [2:0] w, input logic [31:0] a,
                          input logic [31:0] dat, input string tag);
    int rl, lat, idx;
    bit valid, mis, trap, sub, got;
    logic [31:0] old, nw;
    rl    = (d == 0) ? 1 : 3;
    valid = (w == 3'b001) || (w == 3'b010) || (w == 3'b100);
    mis   = ((w == 3'b010) && a[0]) || ((w == 3'b001) && (a[1:0] != 2'b00));
    trap  = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    trap  = mis;
`endif
    idx = int'(a[11:2]);
    old = exp_mem[d][idx];
    nw  = (valid && !trap) ? model_word(old, w, a[1:0], dat) : old;
    sub = valid && !trap && (w != 3'b001);
    lat = sub ? 2 + rl : 1;
    @(negedge clk);
    st_req[d] = 1'b1; st_width[d] = w; st_addr[d] = a; st_data[d] = dat;
    #1;
    check({tag, " stall@N"}, 32'(stall[d]), 32'd1);
    got = 1'b0;
    for (int k = 1; k <= 12 && !got; k++) begin
      @(negedge clk);
      st_addr[d] = $urandom; st_data[d] = $urandom;
      if (st_ack[d]) begin
        got = 1'b1;
        check({tag, " latency"}, 32'(k), 32'(lat));
        check({tag, " stall@ack"}, 32'(stall[d]), 32'd0);
        check({tag, " we@ack"}, 32'(dmem_we[d]), 32'(valid && !trap));
        if (valid && !trap) begin
          check({tag, " addr"}, dmem_addr[d], {a[31:2], 2'b00});
          check({tag, " wdata"}, dmem_wdata[d], nw);
        end
`ifdef STORE_MISALIGN_TRAP_EN
        check({tag, " misalign"}, 32'(st_misalign[d]), 32'(trap));
        if (trap) check({tag, " badaddr"}, st_badaddr[d], a);
`endif
      end else begin
        check({tag, " stall busy"}, 32'(stall[d]), 32'd1);
        if (sub && k == 1) begin
          check({tag, " read en/we"}, {30'd0, dmem_en[d], dmem_we[d]}, 32'd2);
          check({tag, " read addr"}, dmem_addr[d], {a[31:2], 2'b00});
        end
        if (sub && k == 1 + rl) check({tag, " rdata"}, dmem_rdata[d], old);
      end
    end
    if (!got) check({tag, " ack timeout"}, 32'd0, 32'd1);
    st_req[d] = 1'b0;
    exp_mem[d][idx] = nw;
  endtask

  task automatic check_mem(input int d, input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(posedge clk); #1;
    check(tag, mem[d][a[11:2]], exp);
  endtask

  initial begin
    int bad;
    logic [2:0] wsel [8];
    wsel = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b011, 3'b000};
    rst = 1'b1; mem_clr = 1'b1; st_req = 2'b00;
    for (int d = 0; d < 2; d++) begin
      st_width[d] = 3'b000; st_addr[d] = 32'h0; st_data[d] = 32'h0;
      for (int i = 0; i < 1024; i++) exp_mem[d][i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset ctl", {28'd0, dmem_en[d], dmem_we[d], st_ack[d], stall[d]}, 32'd0);
      check("reset addr", dmem_addr[d], 32'h0);
      check("reset wdata", dmem_wdata[d], 32'h0);
    end
    rst = 1'b0; mem_clr = 1'b0;

    do_store(0, 3'b001, 32'h100, 32'hDEADBEEF, "word");
    check_mem(0, 32'h100, 32'hDEADBEEF, "word mem");
    do_store(0, 3'b001, 32'h200, 32'h11223344, "pre200");
    do_store(0, 3'b100, 32'h203, 32'h000000AA, "byte");
    check_mem(0, 32'h200, 32'hAA223344, "byte mem");
    do_store(0, 3'b001, 32'h300, 32'h11223344, "pre300");
    do_store(0, 3'b010, 32'h302, 32'h0000BEEF, "half");
    check_mem(0, 32'h300, 32'hBEEF3344, "half mem");
    do_store(1, 3'b001, 32'h300, 32'h11223344, "pre300 rl3");
    do_store(1, 3'b010, 32'h302, 32'h0000BEEF, "half rl3");
    check_mem(1, 32'h300, 32'hBEEF3344, "half rl3 mem");
    do_store(0, 3'b001, 32'h400, 32'h0, "pre400");
    do_store(0, 3'b100, 32'h401, 32'h55, "b2b first");
    do_store(0, 3'b100, 32'h402, 32'h66, "b2b second");
    check_mem(0, 32'h400, 32'h00665500, "b2b mem");
    do_store(0, 3'b011, 32'h400, 32'hFFFFFFFF, "invalid width");
    check_mem(0, 32'h400, 32'h00665500, "invalid mem");
    do_store(0, 3'b001, 32'h300, 32'h11223344, "pre misalign");
    do_store(0, 3'b010, 32'h301, 32'h0000BEEF, "misalign half");
`ifdef STORE_MISALIGN_TRAP_EN
    check_mem(0, 32'h300, 32'h11223344, "misalign mem");
`else
    check_mem(0, 32'h300, 32'h1122BEEF, "misalign mem");
`endif

    // Reset while waiting on read data: no write, no ack.
    @(negedge clk);
    st_req[1] = 1'b1; st_width[1] = 3'b100; st_addr[1] = 32'h500; st_data[1] = 32'h77;
    @(negedge clk);
    @(negedge clk);
    check("rst wait ack", 32'(st_ack[1]), 32'd0);
    rst = 1'b1; st_req[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst idle ctl", {28'd0, dmem_en[1], dmem_we[1], st_ack[1], stall[1]}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("rst quiet", {30'd0, dmem_we[1], st_ack[1]}, 32'd0);
    end
    check("rst mem", mem[1][32'h500 >> 2], 32'h0);
    do_store(1, 3'b001, 32'h504, 32'hCAFEF00D, "post rst word");
    check_mem(1, 32'h504, 32'hCAFEF00D, "post rst mem");

    for (int n = 0; n < 40; n++) begin
      do_store(int'($urandom_range(0, 1)), wsel[$urandom_range(0, 7)],
               32'($urandom_range(0, 4095)), $urandom, "random");
    end
    repeat (2) @(negedge clk);
    bad = 0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 1024; i++)
        if (mem[d][i] !== exp_mem[d][i]) bad++;
    check("final memory words differing", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
